// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID boundary.
// Contents:
//   WORD_W      instruction and PC width
//   NOP_INSTR   all-zero instruction word (sll $0,$0,0), shown when no entry is valid
//   *_HI/*_LO   MIPS instruction field bit positions
//   *_W         matching field widths
package if_id_buffer_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

   localparam int unsigned OPC_HI   = 31;
   localparam int unsigned OPC_LO   = 26;
   localparam int unsigned RS_HI    = 25;
   localparam int unsigned RS_LO    = 21;
   localparam int unsigned RT_HI    = 20;
   localparam int unsigned RT_LO    = 16;
   localparam int unsigned RD_HI    = 15;
   localparam int unsigned RD_LO    = 11;
   localparam int unsigned SHAMT_HI = 10;
   localparam int unsigned SHAMT_LO = 6;
   localparam int unsigned FUNCT_HI = 5;
   localparam int unsigned FUNCT_LO = 0;
   localparam int unsigned IMM_HI   = 15;
   localparam int unsigned IMM_LO   = 0;

   localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
   localparam int unsigned REG_W   = RS_HI - RS_LO + 1;
   localparam int unsigned SHAMT_W = SHAMT_HI - SHAMT_LO + 1;
   localparam int unsigned FUNCT_W = FUNCT_HI - FUNCT_LO + 1;
   localparam int unsigned IMM_W   = IMM_HI - IMM_LO + 1;

endpackage

// File: rtl/if_id_buffer_instr_field_split.sv
// Combinational splitter from a 32-bit MIPS instruction word to its fields.
// Shared with the decode stage.
// Ports:
//   instr_i   instruction word
//   opcode_o  [31:26]   rs_o [25:21]   rt_o [20:16]   rd_o [15:11]
//   shamt_o   [10:6]    funct_o [5:0]  imm_o [15:0]
module instr_field_split
   import if_id_buffer_pkg::*;
(
   input  logic [WORD_W-1:0]  instr_i,
   output logic [OPC_W-1:0]   opcode_o,
   output logic [REG_W-1:0]   rs_o,
   output logic [REG_W-1:0]   rt_o,
   output logic [REG_W-1:0]   rd_o,
   output logic [SHAMT_W-1:0] shamt_o,
   output logic [FUNCT_W-1:0] funct_o,
   output logic [IMM_W-1:0]   imm_o
);

   assign opcode_o = instr_i[OPC_HI:OPC_LO];
   assign rs_o     = instr_i[RS_HI:RS_LO];
   assign rt_o     = instr_i[RT_HI:RT_LO];
   assign rd_o     = instr_i[RD_HI:RD_LO];
   assign shamt_o  = instr_i[SHAMT_HI:SHAMT_LO];
   assign funct_o  = instr_i[FUNCT_HI:FUNCT_LO];
   assign imm_o    = instr_i[IMM_HI:IMM_LO];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a small circular FIFO of {instr, pc} entries between
// fetch and decode with valid/ready handshakes on both sides, plus a flush that
// drops wrong-path instructions after a taken branch.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   if_valid/if_ready   fetch-side handshake; if_instr, if_pc are the payload
//   flush               empty the buffer and ignore same-cycle push/pop
//   id_valid/id_ready   decode-side handshake on the head entry
//   id_instr, id_pc     head payload (zero when empty)
//   id_pc4              id_pc + 4 (zero when empty)
//   id_opcode..id_imm   MIPS fields of id_instr
//   count               number of occupied entries
// DEPTH must be a power of two >= 2; CW must satisfy 2**CW > DEPTH.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [WORD_W-1:0] if_instr,
   input  logic [WORD_W-1:0] if_pc,
   input  logic              flush,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [WORD_W-1:0] id_instr,
   output logic [WORD_W-1:0] id_pc,
   output logic [WORD_W-1:0] id_pc4,
   output logic [5:0]        id_opcode,
   output logic [4:0]        id_rs,
   output logic [4:0]        id_rt,
   output logic [4:0]        id_rd,
   output logic [4:0]        id_shamt,
   output logic [5:0]        id_funct,
   output logic [15:0]       id_imm,
   output logic [CW-1:0]     count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef logic [PW-1:0] ptr_t;

   logic [WORD_W-1:0] instr_mem_q [DEPTH];
   logic [WORD_W-1:0] pc_mem_q    [DEPTH];

   ptr_t          wr_ptr_q, wr_ptr_d;
   ptr_t          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic push, pop;

   // Ready comes from registered occupancy only, so decode stalls never form a
   // combinational path back into fetch.
   assign if_ready = (count_q != CW'(DEPTH));
   assign id_valid = (count_q != '0);

   assign push = if_valid & if_ready & ~flush;
   assign pop  = id_valid & id_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         instr_mem_q[wr_ptr_q] <= if_instr;
         pc_mem_q[wr_ptr_q]    <= if_pc;
      end
   end

   // Empty buffer presents an all-zero NOP so decode sees harmless fields.
   assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
   assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign id_pc4   = id_valid ? (id_pc + 32'd4)       : '0;
   assign count    = count_q;

   instr_field_split u_split (
      .instr_i  (id_instr),
      .opcode_o (id_opcode),
      .rs_o     (id_rs),
      .rt_o     (id_rt),
      .rd_o     (id_rd),
      .shamt_o  (id_shamt),
      .funct_o  (id_funct),
      .imm_o    (id_imm)
   );

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_shamt;
   logic [5:0]  id_funct;
   logic [15:0] id_imm;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t exp_q[$];

   if_id_buffer #(.DEPTH(2), .CW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .flush     (flush),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_instr  (id_instr),
      .id_pc     (id_pc),
      .id_pc4    (id_pc4),
      .id_opcode (id_opcode),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rd     (id_rd),
      .id_shamt  (id_shamt),
      .id_funct  (id_funct),
      .id_imm    (id_imm),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted pop must match the oldest accepted push.
   always @(negedge clk) begin
      entry_t e;
      if (rst && !flush && id_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_pop actual pc=%h required=no entry", id_pc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", id_pc, e.pc);
            chk("sb_instr", id_instr, e.instr);
            chk("sb_pc4", id_pc4, e.pc + 32'd4);
            chk("sb_opcode", 32'(id_opcode), 32'(e.instr[31:26]));
            chk("sb_rs", 32'(id_rs), 32'(e.instr[25:21]));
            chk("sb_rt", 32'(id_rt), 32'(e.instr[20:16]));
            chk("sb_rd", 32'(id_rd), 32'(e.instr[15:11]));
            chk("sb_shamt", 32'(id_shamt), 32'(e.instr[10:6]));
            chk("sb_funct", 32'(id_funct), 32'(e.instr[5:0]));
            chk("sb_imm", 32'(id_imm), 32'(e.instr[15:0]));
         end
      end
   end

   // Advance one clock; record what the buffer should accept at this edge.
   task automatic tick();
      @(negedge clk);
      if (!rst || flush) exp_q.delete();
      else if (if_valid && if_ready) exp_q.push_back('{instr: if_instr, pc: if_pc});
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b0;
      if_valid = 1'b0;
      if_instr = '0;
      if_pc    = '0;
      flush    = 1'b0;
      id_ready = 1'b0;

      // Reset
      tick();
      tick();
      chk("reset_id_valid", 32'(id_valid), 32'd0);
      chk("reset_if_ready", 32'(if_ready), 32'd1);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_id_instr", id_instr, 32'd0);
      chk("reset_id_pc", id_pc, 32'd0);
      chk("reset_id_pc4", id_pc4, 32'd0);
      chk("reset_id_fields", {16'(id_imm), 5'(id_rs), 5'(id_rt), 6'(id_funct)}, 32'd0);
      rst = 1'b1;

      // Basic flow: add $8,$9,$10
      id_ready = 1'b1;
      push(32'h012A4020, 32'h00400000);
      if_valid = 1'b0;
      chk("basic_id_valid", 32'(id_valid), 32'd1);
      chk("basic_opcode", 32'(id_opcode), 32'd0);
      chk("basic_rs", 32'(id_rs), 32'd9);
      chk("basic_rt", 32'(id_rt), 32'd10);
      chk("basic_rd", 32'(id_rd), 32'd8);
      chk("basic_funct", 32'(id_funct), 32'h20);
      chk("basic_pc4", id_pc4, 32'h00400004);
      tick();
      chk("basic_drained", 32'(count), 32'd0);

      // Back-pressure: third push must be refused
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(32'h20080000 | 32'(i), 32'(i * 4));
      if_valid = 1'b0;
      chk("bp_count", 32'(count), 32'd2);
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      chk("bp_head_pc", id_pc, 32'h0);
      tick();
      chk("bp_hold_pc", id_pc, 32'h0);
      chk("bp_hold_instr", id_instr, 32'h20080000);
      id_ready = 1'b1;
      tick();
      chk("bp_second_pc", id_pc, 32'h4);
      tick();
      chk("bp_count_empty", 32'(count), 32'd0);
      tick();
      tick();
      chk("bp_no_third", 32'(id_valid), 32'd0);

      // Simultaneous push and pop at count=1, across pointer wrap
      id_ready = 1'b0;
      push(32'h8C000010, 32'h10);
      id_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         push(32'h8C000010 + 32'(i), 32'h10 + 32'(i * 4));
         chk("sim_count", 32'(count), 32'd1);
         chk("sim_head_pc", id_pc, 32'h10 + 32'(i * 4));
      end
      if_valid = 1'b0;
      tick();
      chk("sim_drain", 32'(count), 32'd0);

      // Flush with a push presented in the flush cycle
      id_ready = 1'b0;
      push(32'h24020200, 32'h200);
      push(32'h24020204, 32'h204);
      chk("fl_count_before", 32'(count), 32'd2);
      if_valid = 1'b1;
      if_instr = 32'h24020208;
      if_pc    = 32'h208;
      flush    = 1'b1;
      id_ready = 1'b1;
      tick();
      flush    = 1'b0;
      if_valid = 1'b0;
      id_ready = 1'b0;
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_id_valid", 32'(id_valid), 32'd0);
      chk("fl_if_ready", 32'(if_ready), 32'd1);
      push(32'h24020100, 32'h100);
      if_valid = 1'b0;
      chk("fl_new_head", id_pc, 32'h100);
      chk("fl_new_count", 32'(count), 32'd1);
      id_ready = 1'b1;
      tick();
      chk("fl_drained", 32'(count), 32'd0);

      // Reset mid-operation
      id_ready = 1'b0;
      push(32'h24030300, 32'h300);
      push(32'h24030304, 32'h304);
      if_valid = 1'b0;
      chk("rst_mid_before", 32'(count), 32'd2);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_mid_count", 32'(count), 32'd0);
      chk("rst_mid_valid", 32'(id_valid), 32'd0);
      id_ready = 1'b1;
      tick();
      tick();
      chk("rst_mid_no_stale", 32'(id_valid), 32'd0);

      // PC+4 wraps modulo 2^32
      push(32'h0000000C, 32'hFFFFFFFC);
      if_valid = 1'b0;
      chk("pcwrap_pc", id_pc, 32'hFFFFFFFC);
      chk("pcwrap_pc4", id_pc4, 32'h00000000);
      tick();
      tick();

      chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
